eval_sram_to_sram_axi4l_regs: RTL and testbench



---
 rtl/eval_sram_to_sram_axi4l_regs_pkg.sv | 18 +
 rtl/eval_sram_to_sram_axi4l_regs_if.sv | 37 +++
 rtl/eval_sram_to_sram_axi4l_regs_slave_if.sv | 107 ++++++++++
 rtl/eval_sram_to_sram_axi4l_regs.sv | 106 ++++++++++
 tb/tb_eval_sram_to_sram_axi4l_regs.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eval_sram_to_sram_axi4l_regs_pkg.sv
// Shared constants for the SRAM-to-SRAM evaluation control register block.
package eval_sram_to_sram_regs_pkg;

    localparam int unsigned ADR_CORE_ID      = 0;
    localparam int unsigned ADR_CORE_VERSION = 1;
    localparam int unsigned ADR_CTL_CONTROL  = 4;
    localparam int unsigned ADR_CTL_STATUS   = 5;
    localparam int unsigned ADR_PARAM_LEN    = 8;
    localparam int unsigned ADR_CYCLE_COUNT  = 9;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic done_flag;
        logic busy;
    } status_t;

endpackage

// File: rtl/eval_sram_to_sram_axi4l_regs_if.sv
// AXI4-Lite bus bundle between the host (master) and the register block (slave).
interface eval_sram_to_sram_axi4l_regs_if #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64
);
    logic [ADDR_BITS-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_BITS-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/eval_sram_to_sram_axi4l_regs_slave_if.sv
// AXI4-Lite handshake engine: turns AW/W/B/AR/R traffic into single-cycle
// register write and read strobes for the parent register file.
module eval_sram_to_sram_axi4l_slave_if
    import eval_sram_to_sram_regs_pkg::*;
#(
    parameter int AXI4L_ADDR_BITS = 40,
    parameter int AXI4L_DATA_BITS = 64,
    parameter int REGADR_BITS     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    eval_sram_to_sram_axi4l_regs_if.slave axi,
    output logic                         wr_en_o,
    output logic [REGADR_BITS-1:0]       wr_addr_o,
    output logic [AXI4L_DATA_BITS-1:0]   wr_data_o,
    output logic [AXI4L_DATA_BITS/8-1:0] wr_strb_o,
    output logic                         rd_en_o,
    output logic [REGADR_BITS-1:0]       rd_addr_o,
    input  logic [AXI4L_DATA_BITS-1:0]   rd_data_i
);
    logic ready_en_q;
    logic aw_held_q, aw_held_d;
    logic w_held_q, w_held_d;
    logic bvalid_q, bvalid_d;
    logic rvalid_q, rvalid_d;
    logic [AXI4L_DATA_BITS-1:0]   rdata_q, rdata_d;
    logic [REGADR_BITS-1:0]       aw_idx_q;
    logic [AXI4L_DATA_BITS-1:0]   w_data_q;
    logic [AXI4L_DATA_BITS/8-1:0] w_strb_q;
    logic aw_hs, w_hs, ar_hs;

    logic [AXI4L_ADDR_BITS-1:0] unused_addr;
    logic                       unused_prot;
    assign unused_addr = axi.awaddr ^ axi.araddr;
    assign unused_prot = ^{axi.awprot, axi.arprot};

    // Readies stay low while reset is held and come up one cycle after release.
    assign axi.awready = ready_en_q && !aw_held_q && !bvalid_q;
    assign axi.wready  = ready_en_q && !w_held_q && !bvalid_q;
    assign axi.arready = ready_en_q && !rvalid_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = RESP_OKAY;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = RESP_OKAY;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    assign wr_en_o   = aw_held_q && w_held_q && !bvalid_q;
    assign wr_addr_o = aw_idx_q;
    assign wr_data_o = w_data_q;
    assign wr_strb_o = w_strb_q;
    assign rd_en_o   = ar_hs;
    assign rd_addr_o = axi.araddr[REGADR_BITS+2:3];

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        if (wr_en_o) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && axi.bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
        end else if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            bvalid_q   <= bvalid_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // Holding payloads are only consumed behind the held flags, so no reset.
    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_idx_q <= axi.awaddr[REGADR_BITS+2:3];
        if (w_hs) begin
            w_data_q <= axi.wdata;
            w_strb_q <= axi.wstrb;
        end
    end
endmodule

// File: rtl/eval_sram_to_sram_axi4l_regs.sv
// Control/status register file for the SRAM copy engine: start pulse, transfer
// length, sticky done flag and a start-to-done cycle counter.
module eval_sram_to_sram_axi4l_regs
    import eval_sram_to_sram_regs_pkg::*;
#(
    parameter int          AXI4L_ADDR_BITS = 40,
    parameter int          AXI4L_DATA_BITS = 64,
    parameter int          REGADR_BITS     = 8,
    parameter logic [63:0] CORE_ID         = 64'h5352_414d_3253_5241,
    parameter logic [63:0] CORE_VERSION    = 64'h0000_0000_0001_0000
) (
    input  logic                          s_axi4l_aclk,
    input  logic                          s_axi4l_aresetn,
    eval_sram_to_sram_axi4l_regs_if.slave s_axi4l,
    output logic                          start,
    output logic [31:0]                   param_len,
    input  logic                          busy,
    input  logic                          done
);
    logic                         wr_en, rd_en;
    logic [REGADR_BITS-1:0]       wr_addr, rd_addr;
    logic [AXI4L_DATA_BITS-1:0]   wr_data, rd_data;
    logic [AXI4L_DATA_BITS/8-1:0] wr_strb;

    logic        start_q, start_d;
    logic        running_q, running_d;
    logic        done_flag_q, done_flag_d;
    logic [31:0] plen_q, plen_d;
    logic [63:0] count_q, count_d;
    logic        launch, status_clr;
    status_t     status;

    eval_sram_to_sram_axi4l_slave_if #(
        .AXI4L_ADDR_BITS (AXI4L_ADDR_BITS),
        .AXI4L_DATA_BITS (AXI4L_DATA_BITS),
        .REGADR_BITS     (REGADR_BITS)
    ) u_slave (
        .clk_i     (s_axi4l_aclk),
        .rst_ni    (s_axi4l_aresetn),
        .axi       (s_axi4l),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    assign start     = start_q;
    assign param_len = plen_q;

    assign launch = wr_en && (wr_addr == REGADR_BITS'(ADR_CTL_CONTROL)) && wr_strb[0]
                    && wr_data[0] && !busy && !start_q;
    assign status_clr = wr_en && (wr_addr == REGADR_BITS'(ADR_CTL_STATUS)) && wr_strb[0]
                        && wr_data[1];

    always_comb begin
        start_d     = launch;
        running_d   = launch ? 1'b1 : (done ? 1'b0 : running_q);
        done_flag_d = done_flag_q;
        if (done)                       done_flag_d = 1'b1;
        else if (status_clr || launch)  done_flag_d = 1'b0;
        count_d = count_q;
        if (launch)                              count_d = '0;
        else if (running_q && (count_q != '1))   count_d = count_q + 64'd1;
        plen_d = plen_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (wr_addr == REGADR_BITS'(ADR_PARAM_LEN)) && wr_strb[b])
                plen_d[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            start_q     <= 1'b0;
            running_q   <= 1'b0;
            done_flag_q <= 1'b0;
            plen_q      <= '0;
            count_q     <= '0;
        end else begin
            start_q     <= start_d;
            running_q   <= running_d;
            done_flag_q <= done_flag_d;
            plen_q      <= plen_d;
            count_q     <= count_d;
        end
    end

    // Reads see register state before any write landing on the same edge.
    always_comb begin
        status.busy      = busy;
        status.done_flag = done_flag_q;
        rd_data = '0;
        if (rd_en) begin
            case (rd_addr)
                REGADR_BITS'(ADR_CORE_ID):      rd_data = CORE_ID;
                REGADR_BITS'(ADR_CORE_VERSION): rd_data = CORE_VERSION;
                REGADR_BITS'(ADR_CTL_STATUS):   rd_data = AXI4L_DATA_BITS'(status);
                REGADR_BITS'(ADR_PARAM_LEN):    rd_data = AXI4L_DATA_BITS'(plen_q);
                REGADR_BITS'(ADR_CYCLE_COUNT):  rd_data = count_q;
                default:                        rd_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_eval_sram_to_sram_axi4l_regs.sv
// Self-checking bench for the SRAM-to-SRAM AXI4-Lite register block.
module tb_eval_sram_to_sram_axi4l_regs;
    localparam logic [63:0] EXP_ID  = 64'h5352_414d_3253_5241;
    localparam logic [63:0] EXP_VER = 64'h0000_0000_0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic        start;
    logic [31:0] param_len;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;

    eval_sram_to_sram_axi4l_regs_if #(.ADDR_BITS(40), .DATA_BITS(64)) axi ();

    eval_sram_to_sram_axi4l_regs dut (
        .s_axi4l_aclk    (clk),
        .s_axi4l_aresetn (rst_n),
        .s_axi4l         (axi),
        .start           (start),
        .param_len       (param_len),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic axi_write(input logic [39:0] a, input logic [63:0] d,
                             input logic [7:0] s, input int bdly);
        bit aw_p = 1'b1, w_p = 1'b1, aw_hs, w_hs;
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        for (int i = 0; i < 20 && (aw_p || w_p); i++) begin
            aw_hs = axi.awready; w_hs = axi.wready;
            @(negedge clk);
            if (aw_p && aw_hs) begin axi.awvalid = 1'b0; aw_p = 1'b0; end
            if (w_p && w_hs)   begin axi.wvalid = 1'b0;  w_p = 1'b0;  end
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        for (int i = 0; i < 20 && !axi.bvalid; i++) @(negedge clk);
        chk("wr_bvalid", {aw_p, w_p, axi.bvalid}, 3'b001);
        chk("wr_bresp", axi.bresp, 2'b00);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("wr_b_hold", axi.bvalid, 1'b1);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [39:0] a, input int rdly, output logic [63:0] d);
        bit hs = 1'b0;
        axi.araddr = a; axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = axi.arready;
            @(negedge clk);
        end
        axi.arvalid = 1'b0;
        chk("rd_rvalid_1cyc", {hs, axi.rvalid}, 2'b11);
        chk("rd_rresp", axi.rresp, 2'b00);
        d = axi.rdata;
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rd_hold", {axi.rvalid, axi.rdata}, {1'b1, d});
        end
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [39:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [63:0] rd;
        logic [31:0] plen_m;
        bit          dflag_m;
        int          sc0;
        logic [39:0] addrs[9];
        {axi.awaddr, axi.awprot, axi.awvalid, axi.wdata, axi.wstrb, axi.wvalid} = '0;
        {axi.bready, axi.araddr, axi.arprot, axi.arvalid, axi.rready} = '0;

        tbl[0]  = '{0, 40'h00,  64'h0, 8'h00, EXP_ID};
        tbl[1]  = '{0, 40'h08,  64'h0, 8'h00, EXP_VER};
        tbl[2]  = '{1, 40'h40,  64'h1234_5678_9ABC_DEF0, 8'h0F, 64'h9ABC_DEF0};
        tbl[3]  = '{0, 40'h40,  64'h0, 8'h00, 64'h0000_0000_9ABC_DEF0};
        tbl[4]  = '{1, 40'h40,  64'hFFFF_FFFF_1111_2222, 8'h03, 64'h9ABC_2222};
        tbl[5]  = '{0, 40'h40,  64'h0, 8'h00, 64'h9ABC_2222};
        tbl[6]  = '{0, 40'h18,  64'h0, 8'h00, 64'h0};
        tbl[7]  = '{1, 40'h18,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h9ABC_2222};
        tbl[8]  = '{0, 40'h20,  64'h0, 8'h00, 64'h0};
        tbl[9]  = '{0, 40'h28,  64'h0, 8'h00, 64'h0};
        tbl[10] = '{0, 40'h48,  64'h0, 8'h00, 64'h0};
        tbl[11] = '{1, 40'h00,  64'h0, 8'hFF, 64'h9ABC_2222};
        tbl[12] = '{0, 40'h00,  64'h0, 8'h00, EXP_ID};
        tbl[13] = '{0, 40'h7F8, 64'h0, 8'h00, 64'h0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b000);
        chk("rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
        chk("rst_resp_rdata", {axi.bresp, axi.rresp, axi.rdata}, 68'h0);
        chk("rst_start_len", {start, param_len}, 33'h0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3);
                chk($sformatf("tbl%0d_param_len", i), param_len, tbl[i].exp);
            end else begin
                axi_read(tbl[i].addr, i % 3, rd);
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
            end
        end

        // W leads AW by 3 cycles, B held off for 5 cycles
        axi.wdata = 64'h0000_0000_CAFE_F00D; axi.wstrb = 8'hFF; axi.wvalid = 1'b1;
        chk("wfirst_wready", axi.wready, 1'b1);
        @(negedge clk);
        axi.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_no_update", {axi.bvalid, param_len}, {1'b0, 32'h9ABC_2222});
            @(negedge clk);
        end
        axi.awaddr = 40'h40; axi.awvalid = 1'b1;
        chk("wfirst_awready", axi.awready, 1'b1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        chk("wfirst_b_not_yet", axi.bvalid, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("wfirst_b_stall", {axi.bvalid, axi.awready, axi.wready, param_len},
                {3'b100, 32'hCAFE_F00D});
            @(negedge clk);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        chk("wfirst_b_done", {axi.bvalid, axi.awready, axi.wready}, 3'b011);

        // Read in the same cycle as the register update sees the old value
        axi.awaddr = 40'h40; axi.wdata = 64'h1111_2222; axi.wstrb = 8'hFF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 40'h40; axi.arvalid = 1'b1;
        @(negedge clk);
        axi.arvalid = 1'b0;
        chk("rw_same_rdata", {axi.rvalid, axi.bvalid, axi.rdata}, {2'b11, 64'hCAFE_F00D});
        chk("rw_same_len", param_len, 32'h1111_2222);
        axi.rready = 1'b1; axi.bready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0; axi.bready = 1'b0;
        chk("rw_same_release", {axi.rvalid, axi.bvalid}, 2'b00);

        // Start, run ~100 cycles, done
        sc0 = start_cnt;
        axi_write(40'h20, 64'h1, 8'h01, 0);
        busy = 1'b1;
        for (int i = 0; i < 300 && cyc != start_cyc + 99; i++) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; busy = 1'b0;
        chk("start_pulses", start_cnt - sc0, 1);
        axi_read(40'h48, 1, rd);
        n_chk++;
        if (rd >= 99 && rd <= 101) n_pass++;
        else $display("FAIL cycle_count: got %0d expected 100 (+-1)", rd);
        axi_read(40'h28, 0, rd);
        chk("status_done", rd, 64'h2);

        // Start ignored while busy; busy visible live in status
        busy = 1'b1;
        sc0 = start_cnt;
        axi_write(40'h20, 64'h1, 8'h01, 1);
        repeat (3) @(negedge clk);
        chk("busy_no_start", start_cnt - sc0, 0);
        axi_read(40'h28, 0, rd);
        chk("status_busy_done", rd, 64'h3);
        busy = 1'b0;

        // Clear needs wstrb[0]
        axi_write(40'h28, 64'h2, 8'hFE, 0);
        axi_read(40'h28, 0, rd);
        chk("clr_no_strb", rd, 64'h2);
        axi_write(40'h28, 64'h2, 8'h01, 0);
        axi_read(40'h28, 0, rd);
        chk("clr_w1c", rd, 64'h0);

        // done pulse in the same cycle as the clear: set wins
        axi.awaddr = 40'h28; axi.wdata = 64'h2; axi.wstrb = 8'h01;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("setclr_bvalid", axi.bvalid, 1'b1);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        axi_read(40'h28, 0, rd);
        chk("set_wins", rd, 64'h2);

        // start clears done_flag, then finish the run and clear again
        axi_write(40'h20, 64'h1, 8'h01, 0);
        axi_read(40'h28, 0, rd);
        chk("start_clears_done", rd, 64'h0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        axi_write(40'h28, 64'h2, 8'h01, 0);

        // Randomized traffic against a register-map model
        plen_m = 32'h1111_2222;
        dflag_m = 1'b0;
        addrs = '{40'h00, 40'h08, 40'h10, 40'h18, 40'h28, 40'h40, 40'h50, 40'h7F8, 40'h840};
        for (int it = 0; it < 40; it++) begin
            logic [39:0] a;
            logic [63:0] d, exp;
            logic [7:0]  s;
            int          idx;
            a = addrs[$urandom_range(0, 8)];
            idx = int'((a >> 3) & 40'hFF);
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                s = 8'($urandom);
                axi_write(a, d, s, $urandom_range(0, 3));
                if (idx == 8) begin
                    for (int b = 0; b < 4; b++)
                        if (s[b]) plen_m[8*b +: 8] = d[8*b +: 8];
                end else if (idx == 5 && s[0] && d[1]) begin
                    dflag_m = 1'b0;
                end
                chk($sformatf("rnd%0d_len", it), param_len, plen_m);
            end else begin
                axi_read(a, $urandom_range(0, 3), rd);
                case (idx)
                    0:       exp = EXP_ID;
                    1:       exp = EXP_VER;
                    5:       exp = {62'h0, dflag_m, 1'b0};
                    8:       exp = {32'h0, plen_m};
                    default: exp = 64'h0;
                endcase
                chk($sformatf("rnd%0d_rd_%0h", it, a), rd, exp);
            end
        end

        // Reset while a write response is pending
        axi.awaddr = 40'h40; axi.wdata = 64'h55; axi.wstrb = 8'hFF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(negedge clk);
        chk("rstmid_bvalid_pre", axi.bvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async", {axi.bvalid, axi.awready, start, param_len}, 35'h0);
        axi.bready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_b", {axi.bvalid, axi.rvalid}, 2'b00);
        end
        axi.bready = 1'b0;
        axi_read(40'h40, 0, rd);
        chk("rstmid_len_cleared", rd, 64'h0);
        axi_read(40'h00, 0, rd);
        chk("rstmid_alive", rd, EXP_ID);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
